// File: rtl/iob_ptfloat_fpu_ctrl_pkg.sv
// Shared opcodes, FSM state type and helpers for the ptfloat FPU controller.
package iob_ptfloat_fpu_ctrl_pkg;

   localparam int unsigned OPCODE_W = 2;
   localparam int unsigned FLAGS_W  = 3;

   localparam logic [OPCODE_W-1:0] OpAdd = 2'b00;
   localparam logic [OPCODE_W-1:0] OpSub = 2'b01;
   localparam logic [OPCODE_W-1:0] OpMul = 2'b10;
   localparam logic [OPCODE_W-1:0] OpDiv = 2'b11;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StPipe = 2'd1,
      StDiv  = 2'd2
   } ctrl_state_e;

   // Divide is the only non-pipelined FPU operation.
   function automatic logic is_div_op(input logic [OPCODE_W-1:0] op);
      return (op == OpDiv);
   endfunction

endpackage

// File: rtl/iob_ptfloat_fpu_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; push and pop may coincide at any fill level.
module iob_ptfloat_fpu_rsp_fifo #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned WIDTH = 35,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic             cke_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = cke_i & push_i;
   assign w_pop  = cke_i & pop_i & (r_count != '0);

   // Storage needs no reset: only entries covered by r_count are ever read.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= push_data_i;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally (depth is a power of two).
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign pop_data_o = r_mem[r_rptr];
   assign count_o    = r_count;

endmodule

// File: rtl/iob_ptfloat_fpu_ctrl.sv
// Initiator-side controller for iob_ptfloat_fpu: credit-limited issue, in-order buffered responses.
module iob_ptfloat_fpu_ctrl
   import iob_ptfloat_fpu_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned EW_W      = 4,
   parameter int unsigned RES_DEPTH = 4
) (
   input  logic                clk_i,
   input  logic                arst_i,
   input  logic                cke_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [OPCODE_W-1:0] cmd_op_i,
   input  logic [DATA_W-1:0]   cmd_op1_i,
   input  logic [DATA_W-1:0]   cmd_op2_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_data_o,
   output logic                rsp_overflow_o,
   output logic                rsp_underflow_o,
   output logic                rsp_div_by_zero_o,
   output logic [OPCODE_W-1:0] fpu_op_o,
   output logic                fpu_start_o,
   output logic [DATA_W-1:0]   fpu_op1_o,
   output logic [DATA_W-1:0]   fpu_op2_o,
   input  logic                fpu_done_i,
   input  logic [DATA_W-1:0]   fpu_data_i,
   input  logic                fpu_overflow_i,
   input  logic                fpu_underflow_i,
   input  logic                fpu_div_by_zero_i,
   output logic                err_o
);

   localparam int unsigned CNT_W   = $clog2(RES_DEPTH) + 1;
   localparam int unsigned OCC_W   = CNT_W + 1;
   localparam int unsigned ENTRY_W = DATA_W + FLAGS_W;

   if ((RES_DEPTH < 2) || ((RES_DEPTH & (RES_DEPTH - 1)) != 0) || (EW_W >= DATA_W))
   begin : g_bad_params
      $error("iob_ptfloat_fpu_ctrl: RES_DEPTH must be a power of two >= 2, EW_W < DATA_W");
   end

   ctrl_state_e         r_state;
   ctrl_state_e         w_state_d;
   logic [CNT_W-1:0]    r_inflight;
   logic [CNT_W-1:0]    w_inflight_d;
   logic                r_err;
   logic                r_start;
   logic [OPCODE_W-1:0] r_op;
   logic [DATA_W-1:0]   r_op1;
   logic [DATA_W-1:0]   r_op2;

   logic [CNT_W-1:0]    w_fifo_count;
   logic [ENTRY_W-1:0]  w_fifo_rdata;
   logic [ENTRY_W-1:0]  w_rsp_entry;
   logic [OCC_W-1:0]    w_occ;
   logic                w_room;
   logic                w_cmd_ready;
   logic                w_accept;
   logic                w_done_ok;
   logic                w_spurious;
   logic                w_rsp_valid;

   // Every accepted op owns a FIFO slot until popped, so the FPU can never overrun the buffer.
   assign w_occ      = OCC_W'(r_inflight) + OCC_W'(w_fifo_count);
   assign w_room     = (w_occ < OCC_W'(RES_DEPTH));
   assign w_done_ok  = cke_i & fpu_done_i & (r_inflight != '0);
   assign w_spurious = cke_i & fpu_done_i & (r_inflight == '0);

   // Command readiness: depends on state, credit and opcode, never on cmd_valid_i.
   always_comb begin
      w_cmd_ready = 1'b0;
      if (cke_i && !arst_i) begin
         case (r_state)
            StIdle:  w_cmd_ready = w_room;
            StPipe:  w_cmd_ready = w_room & ~is_div_op(cmd_op_i);
            StDiv:   w_cmd_ready = 1'b0;
            default: w_cmd_ready = 1'b0;
         endcase
      end
   end

   assign w_accept    = cmd_valid_i & w_cmd_ready;
   assign cmd_ready_o = w_cmd_ready;

   // Next-state and inflight counter update.
   always_comb begin
      w_state_d    = r_state;
      w_inflight_d = r_inflight + CNT_W'(w_accept) - CNT_W'(w_done_ok);
      case (r_state)
         StIdle: begin
            if (w_accept) w_state_d = is_div_op(cmd_op_i) ? StDiv : StPipe;
         end
         StPipe: begin
            if (!w_accept && (w_inflight_d == '0)) w_state_d = StIdle;
         end
         StDiv: begin
            if (w_done_ok) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // State, counters, sticky error and issue registers; cke_i low freezes everything.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state    <= StIdle;
         r_inflight <= '0;
         r_err      <= 1'b0;
         r_start    <= 1'b0;
         r_op       <= '0;
         r_op1      <= '0;
         r_op2      <= '0;
      end else if (cke_i) begin
         r_state    <= w_state_d;
         r_inflight <= w_inflight_d;
         r_err      <= r_err | w_spurious;
         r_start    <= w_accept;
         if (w_accept) begin
            r_op  <= cmd_op_i;
            r_op1 <= cmd_op1_i;
            r_op2 <= cmd_op2_i;
         end
      end
   end

   iob_ptfloat_fpu_rsp_fifo #(
      .DEPTH (RES_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_rsp_fifo (
      .clk_i       (clk_i),
      .arst_i      (arst_i),
      .cke_i       (cke_i),
      .push_i      (w_done_ok),
      .push_data_i ({fpu_div_by_zero_i, fpu_overflow_i, fpu_underflow_i, fpu_data_i}),
      .pop_i       (w_rsp_valid & rsp_ready_i),
      .pop_data_o  (w_fifo_rdata),
      .count_o     (w_fifo_count)
   );

   assign w_rsp_valid = cke_i & (w_fifo_count != '0);
   // Zero the payload when nothing is presented so stale storage never leaks out.
   assign w_rsp_entry = w_rsp_valid ? w_fifo_rdata : '0;

   assign rsp_valid_o       = w_rsp_valid;
   assign rsp_data_o        = w_rsp_entry[DATA_W-1:0];
   assign rsp_underflow_o   = w_rsp_entry[DATA_W];
   assign rsp_overflow_o    = w_rsp_entry[DATA_W+1];
   assign rsp_div_by_zero_o = w_rsp_entry[DATA_W+2];

   assign fpu_start_o = r_start & cke_i;
   assign fpu_op_o    = r_op;
   assign fpu_op1_o   = r_op1;
   assign fpu_op2_o   = r_op2;
   assign err_o       = r_err;

endmodule

// File: tb/tb_iob_ptfloat_fpu_ctrl.sv
// Directed self-checking bench for iob_ptfloat_fpu_ctrl with a behavioural FPU and a response scoreboard.
module tb_iob_ptfloat_fpu_ctrl;
   import iob_ptfloat_fpu_ctrl_pkg::*;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned RES_DEPTH = 4;

   logic                clk = 1'b0;
   logic                arst = 1'b0;
   logic                cke = 1'b1;
   logic                cmd_valid = 1'b0;
   logic                cmd_ready;
   logic [OPCODE_W-1:0] cmd_op = '0;
   logic [DATA_W-1:0]   cmd_op1 = '0;
   logic [DATA_W-1:0]   cmd_op2 = '0;
   logic                rsp_valid;
   logic                rsp_ready = 1'b1;
   logic [DATA_W-1:0]   rsp_data;
   logic                rsp_ovf, rsp_unf, rsp_dbz;
   logic [OPCODE_W-1:0] fpu_op;
   logic                fpu_start;
   logic [DATA_W-1:0]   fpu_op1, fpu_op2;
   logic                fpu_done;
   logic [DATA_W-1:0]   fpu_data;
   logic                fpu_ovf, fpu_unf, fpu_dbz;
   logic                err;

   int n_chk = 0;
   int n_fail = 0;
   int n_rsp = 0;
   int cyc = 0;
   int start_cyc[$];
   logic [34:0] exp_q[$];
   logic spur_done = 1'b0;
   logic ok;
   int base;

   always #5 clk = ~clk;

   iob_ptfloat_fpu_ctrl #(
      .DATA_W    (DATA_W),
      .EW_W      (4),
      .RES_DEPTH (RES_DEPTH)
   ) dut (
      .clk_i             (clk),
      .arst_i            (arst),
      .cke_i             (cke),
      .cmd_valid_i       (cmd_valid),
      .cmd_ready_o       (cmd_ready),
      .cmd_op_i          (cmd_op),
      .cmd_op1_i         (cmd_op1),
      .cmd_op2_i         (cmd_op2),
      .rsp_valid_o       (rsp_valid),
      .rsp_ready_i       (rsp_ready),
      .rsp_data_o        (rsp_data),
      .rsp_overflow_o    (rsp_ovf),
      .rsp_underflow_o   (rsp_unf),
      .rsp_div_by_zero_o (rsp_dbz),
      .fpu_op_o          (fpu_op),
      .fpu_start_o       (fpu_start),
      .fpu_op1_o         (fpu_op1),
      .fpu_op2_o         (fpu_op2),
      .fpu_done_i        (fpu_done),
      .fpu_data_i        (fpu_data),
      .fpu_overflow_i    (fpu_ovf),
      .fpu_underflow_i   (fpu_unf),
      .fpu_div_by_zero_i (fpu_dbz),
      .err_o             (err)
   );

   // FPU result model: {div_by_zero, overflow, underflow, data}; data = op1 ^ op2,
   // overflow/underflow mirror result bits 31/30, div_by_zero only for div with op2 == 0.
   function automatic logic [34:0] fpu_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] res;
      res = a ^ b;
      return {(op == OpDiv) && (b == 32'd0), res[31], res[30], res};
   endfunction

   // Behavioural FPU: latency 2 for pipelined ops, 8 for div; not affected by controller reset.
   typedef struct packed {logic v; logic [34:0] r;} stage_t;
   stage_t pipe [8] = '{default: '0};

   always @(posedge clk) begin
      for (int i = 0; i < 7; i++) pipe[i] <= pipe[i+1];
      pipe[7] <= '0;
      if (fpu_start) begin
         if (fpu_op == OpDiv) pipe[7] <= '{1'b1, fpu_model(fpu_op, fpu_op1, fpu_op2)};
         else                 pipe[1] <= '{1'b1, fpu_model(fpu_op, fpu_op1, fpu_op2)};
      end
   end

   assign fpu_done = pipe[0].v | spur_done;
   assign fpu_data = pipe[0].r[31:0];
   assign fpu_unf  = pipe[0].r[32];
   assign fpu_ovf  = pipe[0].r[33];
   assign fpu_dbz  = pipe[0].r[34];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (fpu_start) start_cyc.push_back(cyc);

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
      n_chk++;
      assert (got === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
      end
   endtask

   // Scoreboard: every handshaken response is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (!arst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 1'b0);
         else check("rsp", {rsp_dbz, rsp_ovf, rsp_unf, rsp_data}, exp_q.pop_front());
         n_rsp++;
      end
   end

   // Present a command and wait up to max_wait cycles for acceptance; leaves cmd_valid high.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int max_wait, output logic acc);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = op; cmd_op1 = a; cmd_op2 = b;
      acc = 1'b0;
      for (int i = 0; i < max_wait; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            acc = 1'b1;
            break;
         end
         if (i < max_wait - 1) begin
            @(posedge clk); #1;
         end
      end
      if (acc) exp_q.push_back(fpu_model(op, a, b));
   endtask

   task automatic idle();
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target, input int budget);
      for (int i = 0; i < budget && n_rsp < target; i++) @(negedge clk);
      check("rsp_count", n_rsp, target);
   endtask

   logic [104:0] all_out;
   assign all_out = {cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_unf, rsp_dbz, fpu_op,
                     fpu_start, fpu_op1, fpu_op2, err};

   initial begin
      // Reset
      #1 arst = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_outputs", all_out, '0);
      @(posedge clk); #1 arst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", cmd_ready, 1'b1);
      check("err_after_reset", err, 1'b0);

      // Clock enable low blocks acceptance
      @(posedge clk); #1;
      cke = 1'b0; cmd_valid = 1'b1; cmd_op = OpAdd; cmd_op1 = 32'h1; cmd_op2 = 32'h2;
      @(negedge clk);
      check("cke_ready", cmd_ready, 1'b0);
      check("cke_start", fpu_start, 1'b0);
      @(posedge clk); #1;
      cke = 1'b1; cmd_valid = 1'b0;

      // Back-to-back pipelined issue
      start_cyc.delete();
      issue(OpAdd, 32'hc0000001, 32'ha0000002, 1, ok);
      check("b2b_accept_add", ok, 1'b1);
      issue(OpSub, 32'h0000000f, 32'ha0000002, 1, ok);
      check("b2b_accept_sub", ok, 1'b1);
      idle();
      wait_rsp(2, 20);
      check("b2b_start_count", start_cyc.size(), 2);
      if (start_cyc.size() == 2) check("b2b_start_gap", start_cyc[1] - start_cyc[0], 1);

      // Backpressure: credit limit of RES_DEPTH
      base = n_rsp;
      @(posedge clk); #1 rsp_ready = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         issue(OpMul, 32'(n), 32'hb0000002, 1, ok);
         check("bp_accept", ok, 1'b1);
      end
      issue(OpMul, 32'd5, 32'hb0000002, 4, ok);
      check("bp_held", ok, 1'b0);
      check("bp_rsp_waiting", rsp_valid, 1'b1);
      @(posedge clk); #1 rsp_ready = 1'b1;
      issue(OpMul, 32'd5, 32'hb0000002, 20, ok);
      check("bp_accept5", ok, 1'b1);
      issue(OpMul, 32'd6, 32'hb0000002, 20, ok);
      check("bp_accept6", ok, 1'b1);
      idle();
      wait_rsp(base + 6, 60);

      // Divide waits for the pipeline to drain
      start_cyc.delete();
      base = n_rsp;
      issue(OpAdd, 32'h12345678, 32'h0000ffff, 1, ok);
      check("div_pre_add", ok, 1'b1);
      issue(OpDiv, 32'h0002000f, 32'h00000000, 1, ok);
      check("div_held", ok, 1'b0);
      issue(OpDiv, 32'h0002000f, 32'h00000000, 20, ok);
      check("div_accept", ok, 1'b1);
      idle();
      wait_rsp(base + 2, 40);
      check("div_start_count", start_cyc.size(), 2);
      if (start_cyc.size() == 2) check("div_start_gap", start_cyc[1] - start_cyc[0], 4);

      // Spurious done
      check("err_clear", err, 1'b0);
      @(posedge clk); #1 spur_done = 1'b1;
      @(posedge clk); #1 spur_done = 1'b0;
      @(negedge clk);
      check("spur_err", err, 1'b1);
      check("spur_no_rsp", rsp_valid, 1'b0);
      repeat (3) @(negedge clk);
      check("spur_err_sticky", err, 1'b1);

      // Reset in the middle of a divide
      @(posedge clk); #1 arst = 1'b1;
      @(posedge clk); #1 arst = 1'b0;
      @(negedge clk);
      check("err_cleared_by_reset", err, 1'b0);
      start_cyc.delete();
      issue(OpDiv, 32'hdeadbeef, 32'h00000001, 1, ok);
      check("mid_div_accept", ok, 1'b1);
      idle();
      for (int i = 0; i < 20 && start_cyc.size() == 0; i++) @(negedge clk);
      check("mid_div_started", start_cyc.size(), 1);
      repeat (3) @(posedge clk);
      #1 arst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_div_reset_outputs", all_out, '0);
      @(posedge clk); #1 arst = 1'b0;
      @(negedge clk);
      check("mid_div_err_before_done", err, 1'b0);
      repeat (8) @(negedge clk);
      check("late_done_err", err, 1'b1);
      check("late_done_no_rsp", rsp_valid, 1'b0);
      check("late_done_ready", cmd_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
